// File: rtl/intersection_phase_scheduler.sv
// Round-robin phase arbiter and lamp driver for a two-street intersection with a pedestrian walk.
// Timed states run off a tick prescaler; greens rest indefinitely until a competitor is pending.
//
// state   | meaning
// ALL_RED | clearance interval between grants, both streets red
// A_GRN   | street A green (resting phase when nothing is pending)
// A_YEL   | street A yellow
// B_GRN   | street B green
// B_YEL   | street B yellow
// WALK    | pedestrian walk, both streets red
module intersection_phase_scheduler #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int T_MIN_GREEN = 10,
  parameter int T_MAX_GREEN = 30,
  parameter int T_YELLOW    = 4,
  parameter int T_ALL_RED   = 2,
  parameter int T_WALK      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sa,
  input  logic       sb,
  input  logic       ped_req,
  output logic       red_a,
  output logic       yel_a,
  output logic       grn_a,
  output logic       red_b,
  output logic       yel_b,
  output logic       grn_b,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    A_GRN   = 3'd1,
    A_YEL   = 3'd2,
    B_GRN   = 3'd3,
    B_YEL   = 3'd4,
    WALK    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    LAST_A = 2'd0,
    LAST_B = 2'd1,
    LAST_P = 2'd2
  } last_t;

  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [8:0]     MIN_G     = 9'(T_MIN_GREEN);
  localparam logic [8:0]     MAX_G     = 9'(T_MAX_GREEN);
  localparam logic [8:0]     YEL_T     = 9'(T_YELLOW);
  localparam logic [8:0]     ALLRED_T  = 9'(T_ALL_RED);
  localparam logic [8:0]     WALK_T    = 9'(T_WALK);

  state_t        state_q, state_d;
  last_t         last_q, last_d;
  logic          req_a_q, req_a_d;
  logic          req_b_q, req_b_d;
  logic          req_p_q, req_p_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    elapsed_q, elapsed_d;

  logic          tick;
  logic [8:0]    el1;
  logic          state_chg;
  state_t        grant;

  assign tick      = (presc_q == PRESC_MAX);
  // Tick count including the current tick, widened so saturation at 255 still compares correctly
  assign el1       = {1'b0, elapsed_q} + 9'd1;
  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ALL_RED;
      last_q    <= LAST_P;
      req_a_q   <= 1'b0;
      req_b_q   <= 1'b0;
      req_p_q   <= 1'b0;
      presc_q   <= '0;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      req_a_q   <= req_a_d;
      req_b_q   <= req_b_d;
      req_p_q   <= req_p_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
    end
  end

  // Round-robin scan starting after the last served requester; rest on A when idle
  always_comb begin
    grant = A_GRN;
    unique case (last_q)
      LAST_A: begin
        if (req_b_q)      grant = B_GRN;
        else if (req_p_q) grant = WALK;
        else if (req_a_q) grant = A_GRN;
      end
      LAST_B: begin
        if (req_p_q)      grant = WALK;
        else if (req_a_q) grant = A_GRN;
        else if (req_b_q) grant = B_GRN;
      end
      default: begin
        if (req_a_q)      grant = A_GRN;
        else if (req_b_q) grant = B_GRN;
        else if (req_p_q) grant = WALK;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ALL_RED: begin
        if (tick && el1 >= ALLRED_T) state_d = grant;
      end
      A_GRN: begin
        if (tick && el1 >= MIN_G && (req_b_q || req_p_q) && (!sa || el1 >= MAX_G))
          state_d = A_YEL;
      end
      A_YEL: begin
        if (tick && el1 >= YEL_T) begin
          state_d = ALL_RED;
          last_d  = LAST_A;
        end
      end
      B_GRN: begin
        if (tick && el1 >= MIN_G && (req_a_q || req_p_q) && (!sb || el1 >= MAX_G))
          state_d = B_YEL;
      end
      B_YEL: begin
        if (tick && el1 >= YEL_T) begin
          state_d = ALL_RED;
          last_d  = LAST_B;
        end
      end
      WALK: begin
        if (tick && el1 >= WALK_T) begin
          state_d = ALL_RED;
          last_d  = LAST_P;
        end
      end
      default: state_d = ALL_RED;
    endcase
  end

  always_comb begin
    presc_d   = presc_q + 1'b1;
    elapsed_d = elapsed_q;
    if (state_chg || tick) presc_d = '0;
    if (state_chg)                         elapsed_d = '0;
    else if (tick && elapsed_q != 8'hFF)   elapsed_d = elapsed_q + 8'd1;
  end

  // Entering the granted state clears its latch, overriding a same-cycle set
  always_comb begin
    req_a_d = req_a_q | (sa      && state_q != A_GRN);
    req_b_d = req_b_q | (sb      && state_q != B_GRN);
    req_p_d = req_p_q | (ped_req && state_q != WALK);
    if (state_d == A_GRN) req_a_d = 1'b0;
    if (state_d == B_GRN) req_b_d = 1'b0;
    if (state_d == WALK)  req_p_d = 1'b0;
  end

  always_comb begin
    red_a = 1'b1;
    yel_a = 1'b0;
    grn_a = 1'b0;
    red_b = 1'b1;
    yel_b = 1'b0;
    grn_b = 1'b0;
    walk  = 1'b0;
    phase = state_q;
    unique case (state_q)
      A_GRN: begin red_a = 1'b0; grn_a = 1'b1; end
      A_YEL: begin red_a = 1'b0; yel_a = 1'b1; end
      B_GRN: begin red_b = 1'b0; grn_b = 1'b1; end
      B_YEL: begin red_b = 1'b0; yel_b = 1'b1; end
      WALK:  walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: a cycle-count reference model predicts each phase entry (phase, cycle);
// a monitor compares every observed phase change, its lamps, and safety invariants.
module tb_intersection_phase_scheduler;

  localparam int TD     = 4;
  localparam int T_MIN  = 2;
  localparam int T_MAX  = 4;
  localparam int T_Y    = 1;
  localparam int T_AR   = 1;
  localparam int T_WLK  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sa = 1'b0, sb = 1'b0, ped_req = 1'b0;
  logic       red_a, yel_a, grn_a, red_b, yel_b, grn_b, walk;
  logic [2:0] phase;

  intersection_phase_scheduler #(
    .TICK_DIV(TD), .T_MIN_GREEN(T_MIN), .T_MAX_GREEN(T_MAX),
    .T_YELLOW(T_Y), .T_ALL_RED(T_AR), .T_WALK(T_WLK)
  ) dut (
    .clk(clk), .reset(reset), .sa(sa), .sb(sb), .ped_req(ped_req),
    .red_a(red_a), .yel_a(yel_a), .grn_a(grn_a),
    .red_b(red_b), .yel_b(yel_b), .grn_b(grn_b),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct { int ph; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: phase, cycles spent in it, last served requester, pending set
  int m_state, m_cnt, m_last, scyc;
  bit pend[3];

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Requester r (0=A,1=B,2=P) is served by phase 1, 3, 5
  function automatic int gph(input int r);
    return 2 * r + 1;
  endfunction

  // {red_a,yel_a,grn_a,red_b,yel_b,grn_b,walk}
  function automatic logic [6:0] lamps_of(input int ph);
    lamps_of = {ph != 1 && ph != 2, ph == 2, ph == 1,
                ph != 3 && ph != 4, ph == 4, ph == 3, ph == 5};
  endfunction

  function automatic logic [6:0] dut_lamps();
    return {red_a, yel_a, grn_a, red_b, yel_b, grn_b, walk};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_last = 2; scyc = 0;
    for (int r = 0; r < 3; r++) pend[r] = 1'b0;
  endtask

  // Called at a negedge with inputs already applied; predicts the following posedge
  task automatic model_eval();
    bit inr[3];
    bit tk;
    int el1, nx;
    inr[0] = sa; inr[1] = sb; inr[2] = ped_req;
    tk  = ((m_cnt + 1) % TD) == 0;
    el1 = (m_cnt + 1) / TD;
    nx  = m_state;
    case (m_state)
      0: if (tk && el1 >= T_AR) begin
           nx = 1;
           for (int k = 3; k >= 1; k--) if (pend[(m_last + k) % 3]) nx = gph((m_last + k) % 3);
         end
      1: if (tk && el1 >= T_MIN && (pend[1] || pend[2]) && (!inr[0] || el1 >= T_MAX)) nx = 2;
      2: if (tk && el1 >= T_Y) begin nx = 0; m_last = 0; end
      3: if (tk && el1 >= T_MIN && (pend[0] || pend[2]) && (!inr[1] || el1 >= T_MAX)) nx = 4;
      4: if (tk && el1 >= T_Y) begin nx = 0; m_last = 1; end
      5: if (tk && el1 >= T_WLK) begin nx = 0; m_last = 2; end
      default: nx = 0;
    endcase
    for (int r = 0; r < 3; r++) begin
      if (gph(r) == nx) pend[r] = 1'b0;
      else if (inr[r] && gph(r) != m_state) pend[r] = 1'b1;
    end
    if (nx != m_state) begin
      exp_q.push_back('{nx, scyc + 1});
      m_cnt = 0;
    end else m_cnt++;
    m_state = nx;
    scyc++;
  endtask

  task automatic step(input logic a, input logic b, input logic p);
    sa = a; sb = b; ped_req = p;
    model_eval();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops a prediction whenever the DUT phase changes
  initial begin
    int prev, mc;
    exp_t e;
    prev = 0; mc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        mc = 0; prev = 0;
      end else begin
        mc++;
        if (int'(phase) != prev) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_phase_change", int'(phase), prev);
          end else begin
            e = exp_q.pop_front();
            chk(int'(phase) == e.ph, "phase_value", int'(phase), e.ph);
            chk(mc == e.cyc, "phase_entry_cycle", mc, e.cyc);
            chk(dut_lamps() == lamps_of(e.ph), "lamps", int'(dut_lamps()), int'(lamps_of(e.ph)));
            if (e.ph == 1) chk(dut.req_a_q == 1'b0, "req_a_clear_on_entry", int'(dut.req_a_q), 0);
            if (e.ph == 3) chk(dut.req_b_q == 1'b0, "req_b_clear_on_entry", int'(dut.req_b_q), 0);
            if (e.ph == 5) chk(dut.req_p_q == 1'b0, "req_p_clear_on_entry", int'(dut.req_p_q), 0);
          end
          prev = int'(phase);
        end
        if (grn_a && grn_b) chk(1'b0, "safety_two_greens", 1, 0);
        if (walk && (grn_a || grn_b || yel_a || yel_b)) chk(1'b0, "safety_walk_conflict", 1, 0);
      end
    end
  end

  initial begin
    int n;
    bit sa_hold;
    #1;
    chk(phase == 3'd0, "reset_phase", int'(phase), 0);
    chk(dut_lamps() == lamps_of(0), "reset_lamps", int'(dut_lamps()), int'(lamps_of(0)));
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    idle(104);
    chk(grn_a == 1'b1, "rest_on_a", int'(grn_a), 1);
    step(1'b0, 1'b1, 1'b0);
    idle(40);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(40);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
    idle(30);
    step(1'b0, 1'b1, 1'b1);
    idle(80);

    sa_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) sa_hold = ($urandom_range(0, 2) == 0);
      step(sa_hold | ($urandom_range(0, 19) == 0),
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 39) == 0);
    end

    n = 0;
    while (m_state != 2 && n < 500) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    chk(phase == 3'd2, "reached_a_yel", int'(phase), 2);
    #1;
    reset = 1'b0;
    sa = 1'b0; sb = 1'b0; ped_req = 1'b0;
    exp_q.delete();
    #1;
    chk(phase == 3'd0, "async_reset_phase", int'(phase), 0);
    chk(yel_a == 1'b0, "async_reset_yel_a", int'(yel_a), 0);
    chk(dut_lamps() == lamps_of(0), "async_reset_lamps", int'(dut_lamps()), int'(lamps_of(0)));
    chk({dut.req_a_q, dut.req_b_q, dut.req_p_q} == 3'b000, "async_reset_latches",
        int'({dut.req_a_q, dut.req_b_q, dut.req_p_q}), 0);
    chk(dut.elapsed_q == 8'd0, "async_reset_elapsed", int'(dut.elapsed_q), 0);
    chk(dut.last_q == 2'd2, "async_reset_last", int'(dut.last_q), 2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle(3);
    chk(grn_a == 1'b0, "grn_a_low_before_4", int'(grn_a), 0);
    idle(1);
    chk(grn_a == 1'b1, "grn_a_after_4", int'(grn_a), 1);
    idle(20);

    @(posedge clk);
    #2;
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Arbiter and phase sequencer for a two-street intersection with a pedestrian crossing. The intersection is one shared resource with three requesters: street A, street B, and the pedestrian walk. The block grants it round-robin, enforces minimum and maximum green, yellow, and all-red clearance timing with an internal seconds prescaler, and drives the lamp outputs directly. It replaces fixed-step light sequencing in the traffic-control design.

## Interface
Parameters:
- TICK_DIV, default 50_000_000: clk cycles per timing tick (1 s); must be ≥1.
- T_MIN_GREEN, default 10: minimum green, in ticks.
- T_MAX_GREEN, default 30: maximum green when the own sensor extends the phase, in ticks.
- T_YELLOW, default 4: yellow duration, in ticks.
- T_ALL_RED, default 2: all-red clearance, in ticks.
- T_WALK, default 8: pedestrian walk duration, in ticks.
- Constraint: all T_* values are 1..255, and T_MIN_GREEN ≤ T_MAX_GREEN.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low.
- sa, input, 1: car sensor, street A (synchronous to clk).
- sb, input, 1: car sensor, street B.
- ped_req, input, 1: pedestrian push-button.
- red_a / yel_a / grn_a, output, 1 each: street A lamps.
- red_b / yel_b / grn_b, output, 1 each: street B lamps.
- walk, output, 1: pedestrian walk lamp.
- phase, output, 3: current state encoding.

## Operation
- **States and `phase` encoding:**
  - ALL_RED=0, A_GRN=1, A_YEL=2, B_GRN=3, B_YEL=4, WALK=5.
  - Moore outputs decoded from the state.
  - A_YEL→ALL_RED, B_YEL→ALL_RED, and WALK→ALL_RED each record `last` = A, B, or P respectively.
- **Lamp decode:**
  - red_a=1 unless the state is A_GRN or A_YEL.
  - red_b=1 unless the state is B_GRN or B_YEL.
  - grn_a/yel_a and grn_b/yel_b are 1 only in their own state.
  - walk=1 only in WALK.
- **Request latches (req_a, req_b, req_p):**
  - A latch sets when its input is 1 and its phase is not currently granted.
  - It clears on the cycle its green/WALK state is entered; the clear wins over a same-cycle set.
- **Timing counters:**
  - Prescaler counts 0..TICK_DIV-1; `tick` = (prescaler == TICK_DIV-1).
  - `elapsed` is 8 bits and counts ticks, saturating at 255.
  - Both counters clear on every state change.
  - `done(T)` = tick && (elapsed+1 ≥ T).
- **Transitions (evaluated only on a tick cycle; state changes at the next edge):**
  - ALL_RED: on done(T_ALL_RED), grant the first pending request scanning round-robin from the requester after `last` (order A→B→P→A). If nothing is pending, go to A_GRN (rest on A).
  - A_GRN: exit to A_YEL on tick when elapsed+1 ≥ T_MIN_GREEN, (req_b | req_p), and (!sa | elapsed+1 ≥ T_MAX_GREEN). With no competing request, A_GRN holds indefinitely.
  - B_GRN: symmetric, using sb and competing requests (req_a | req_p). With no competing request, B_GRN holds indefinitely.
  - A_YEL, B_YEL: on done(T_YELLOW), go to ALL_RED.
  - WALK: on done(T_WALK), go to ALL_RED.
- **Reset value:** the reset value of `last` is P, so the first grant scan starts at A.

## Timing
- **Reset:** asserting reset (async, mid-operation included) immediately forces the following, in the same cycle without waiting for a clock:
  - state=ALL_RED, last=P.
  - All latches 0; prescaler=0, elapsed=0.
  - Outputs: red_a=1, red_b=1, all other lamps 0, phase=0.
- **Timed-state duration:** a timed state lasts exactly T×TICK_DIV cycles from entry.
- **Green length:** green lasts a whole number of ticks, between T_MIN_GREEN and T_MAX_GREEN whenever a competitor is pending.
- **Request-to-release latency:** a request pulse of a single cycle is sufficient. It ends a resting green at the first tick that meets the exit condition.
- **Safety:** grn_a and grn_b are never 1 together. walk is never 1 with any green or yellow. At least T_ALL_RED ticks separate any two grants.
- **Edge case, TICK_DIV=1:** tick is asserted every cycle.

## Test plan
Parameters for all scenarios: TICK_DIV=4, T_MIN_GREEN=2, T_MAX_GREEN=4, T_YELLOW=1, T_ALL_RED=1, T_WALK=3.

1. **Reset release, no requests:** phase=0 for 4 cycles with red_a=red_b=1, then grn_a=1. grn_a stays high for 100 more cycles.
2. **sb single-cycle pulse 1 cycle after A_GRN entry:** A_GRN lasts 8 cycles, A_YEL 4, ALL_RED 4, then B_GRN. req_b reads 0 on the B_GRN entry cycle.
3. **sa held high, sb pulsed:** A_GRN lasts 16 cycles (maximum green), then A_YEL.
4. **sb and ped_req pulsed in the same cycle during A_GRN:** grant order is B_GRN, then WALK (12 cycles, walk=1, red_a=red_b=1), then ALL_RED. A_GRN follows with sa idle.
5. **sa pulsed during B_GRN:** sa is latched and B releases after minimum green. sb asserted on the B_GRN entry cycle does not set req_b.
6. **Reset asserted mid A_YEL:** phase=0 and yel_a=0 in the same cycle, without waiting for a clock edge. All latches read 0. After release, grn_a rises 4 cycles later.
